lfsr_seq_ctrl: RTL and testbench

- Controller that sequences a Fibonacci LFSR sequence generator under a start/busy/done handshake.
- Loads a seed, with a forbidden all-zero seed replaced by DEFAULT_SEED, then steps the LFSR exactly num_steps times.
- Each state is presented on a valid/ready output stream with backpressure.
- Measures the sequence period (steps until the state returns to the seed). Used as a test-pattern/scrambler source.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_core.sv | 42 ++++
 rtl/lfsr_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM state type and default LFSR constants
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    localparam int         LFSR_WIDTH = 3;
    localparam logic [2:0] LFSR_TAPS  = 3'b101;
    localparam logic [2:0] LFSR_SEED  = 3'b001;
    localparam int         LFSR_CNT_W = 8;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with load and step
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = LFSR_TAPS,
    parameter logic [WIDTH-1:0] RESET_VAL = LFSR_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        next    = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        state_d = state_q;
        // A load always wins so a new run starts exactly at its seed
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - start/busy/done sequencer streaming LFSR states with period detection
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_SEED,
    parameter int               CNT_W        = LFSR_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bit,
    output logic             busy,
    output logic             done,
    output logic             period_hit,
    output logic [CNT_W-1:0] period_len
);

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] steps_l_q, steps_l_d;
    logic [WIDTH-1:0] seed_l_q, seed_l_d;
    logic             period_hit_q, period_hit_d;
    logic [CNT_W-1:0] period_len_q, period_len_d;

    logic             load;
    logic             step;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] lfsr_next;
    logic [CNT_W-1:0] count_inc;

    lfsr_core #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .RESET_VAL (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (seed_l_d),
        .step     (step),
        .state    (lfsr_state),
        .next     (lfsr_next)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        fsm_d        = fsm_q;
        count_d      = count_q;
        steps_l_d    = steps_l_q;
        seed_l_d     = seed_l_q;
        period_hit_d = period_hit_q;
        period_len_d = period_len_q;
        load         = 1'b0;
        step         = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    seed_l_d     = (seed == '0) ? DEFAULT_SEED : seed;
                    steps_l_d    = num_steps;
                    count_d      = '0;
                    period_hit_d = 1'b0;
                    period_len_d = '0;
                    load         = 1'b1;
                    fsm_d        = (num_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // abort withdraws valid in the same cycle so no transfer is half-taken
                out_valid = !abort;
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else if (out_ready) begin
                    step    = 1'b1;
                    count_d = count_inc;
                    if (lfsr_next == seed_l_q && !period_hit_q) begin
                        period_hit_d = 1'b1;
                        period_len_d = count_inc;
                    end
                    if (count_inc == steps_l_q) begin
                        fsm_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy  = 1'b1;
                done  = !abort;
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q        <= ST_IDLE;
            count_q      <= '0;
            steps_l_q    <= '0;
            seed_l_q     <= DEFAULT_SEED;
            period_hit_q <= 1'b0;
            period_len_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            count_q      <= count_d;
            steps_l_q    <= steps_l_d;
            seed_l_q     <= seed_l_d;
            period_hit_q <= period_hit_d;
            period_len_q <= period_len_d;
        end
    end

    assign out_data   = lfsr_state;
    assign out_bit    = lfsr_state[WIDTH-1];
    assign period_hit = period_hit_q;
    assign period_len = period_len_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - self-checking bench for lfsr_seq_ctrl against a sequence-table model
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] seed = 3'b000;
    logic [7:0] num_steps = 8'd0;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_bit;
    logic       busy;
    logic       done;
    logic       period_hit;
    logic [7:0] period_len;

    int checks = 0;
    int errors = 0;
    int pat[$];

    // The maximal-length orbit of the default polynomial, in stepping order
    logic [2:0] order [7] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};

    lfsr_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .num_steps  (num_steps),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_bit    (out_bit),
        .busy       (busy),
        .done       (done),
        .period_hit (period_hit),
        .period_len (period_len)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] next_of(input logic [2:0] s);
        for (int i = 0; i < 7; i++) begin
            if (order[i] == s) return order[(i + 1) % 7];
        end
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready held high, 1 random ready plus ignored starts, 2 ready from pat queue
    // stop_kind: 0 run to completion, 1 abort after stop_at transfers, 2 reset after stop_at
    task automatic run(input logic [2:0] sd, input int n, input int rmode,
                       input int stop_at, input int stop_kind);
        logic [2:0] se;
        logic [2:0] cur;
        logic       hit_e;
        int         ret;
        int         got;
        int         cyc;
        se  = (sd == 3'b000) ? 3'b001 : sd;
        ret = 0;
        cur = se;
        for (int i = 1; i <= n; i++) begin
            cur = next_of(cur);
            if (cur == se) begin
                ret = i;
                break;
            end
        end
        cur = se;
        got = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; seed = sd; num_steps = n[7:0]; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (got < n && !(stop_kind != 0 && got == stop_at)) begin
            if (cyc >= 1000) begin
                chk("timeout_transfers", got, n);
                break;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom);
                default: out_ready = (pat.size() > 0) ? 1'(pat.pop_front()) : 1'b1;
            endcase
            if (rmode == 1) begin
                start = 1'($urandom); seed = 3'($urandom); num_steps = 8'($urandom);
            end
            #1;
            hit_e = (ret != 0) && (ret <= got);
            chk("run_valid", 32'(out_valid), 1);
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
            chk("run_data", 32'(out_data), 32'(cur));
            chk("run_bit", 32'(out_bit), 32'(cur[2]));
            chk("run_hit", 32'(period_hit), 32'(hit_e));
            chk("run_len", 32'(period_len), hit_e ? ret : 0);
            if (out_ready) begin
                cur = next_of(cur);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        hit_e = (ret != 0) && (ret <= got);
        case (stop_kind)
            0: begin
                #1;
                chk("done_pulse", 32'(done), 1);
                chk("done_busy", 32'(busy), 1);
                chk("done_valid", 32'(out_valid), 0);
                chk("done_hit", 32'(period_hit), 32'(hit_e));
                chk("done_len", 32'(period_len), hit_e ? ret : 0);
                chk("done_data", 32'(out_data), 32'(cur));
                @(negedge clk);
                #1;
                chk("after_done", 32'(done), 0);
                chk("after_busy", 32'(busy), 0);
                chk("after_valid", 32'(out_valid), 0);
            end
            1: begin
                abort = 1'b1;
                out_ready = 1'b1;
                #1;
                chk("abort_valid", 32'(out_valid), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_busy", 32'(busy), 1);
                @(negedge clk);
                abort = 1'b0;
                out_ready = 1'b0;
                #1;
                chk("abort_idle_busy", 32'(busy), 0);
                chk("abort_idle_done", 32'(done), 0);
                chk("abort_keep_data", 32'(out_data), 32'(cur));
                chk("abort_keep_hit", 32'(period_hit), 32'(hit_e));
                chk("abort_keep_len", 32'(period_len), hit_e ? ret : 0);
            end
            default: begin
                #2;
                reset = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_valid", 32'(out_valid), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_data", 32'(out_data), 32'h1);
                chk("rst_hit", 32'(period_hit), 0);
                chk("rst_len", 32'(period_len), 0);
                #1;
                reset = 1'b1;
            end
        endcase
    endtask

    initial begin
        #12;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_hit", 32'(period_hit), 0);
        chk("reset_len", 32'(period_len), 0);
        chk("reset_data", 32'(out_data), 32'h1);
        @(negedge clk);
        reset = 1'b1;

        run(3'b001, 7, 0, 0, 0);
        run(3'b000, 3, 0, 0, 0);
        pat = '{1, 0, 0, 1, 1, 0, 1};
        run(3'b110, 4, 2, 0, 0);
        run(3'b010, 0, 0, 0, 0);
        run(3'b011, 10, 1, 2, 1);

        @(negedge clk);
        abort = 1'b1; start = 1'b1; seed = 3'b101; num_steps = 8'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_valid", 32'(out_valid), 0);

        run(3'b001, 20, 1, 9, 2);
        run(3'b101, 2, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            run(3'($urandom), $urandom_range(1, 24), 1, 0, 0);
        end
        run(3'b100, 255, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
